pit_host: RTL and testbench

Bus initiator for i8253-compatible interval timers. Takes one high-level command at a time (program a counter, or latch-and-read a counter) and expands it into the byte-wide cs/rd/wr/a access sequence the timer expects. It returns a single response per command. Sits between the microcode/IO controller and the timer, on the same clock as the timer's system clock.

---
 rtl/pit_host_if.sv | 31 +++
 rtl/pit_host.sv | 198 +++++++++++++++++++
 tb/tb_pit_host.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pit_host_if.sv
// Command/response channel and i8253 byte-bus signals of pit_host.
// The master modport is the pit_host side; slave is the controller/timer side.
interface pit_host_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [1:0]  cmd_chan;
   logic [1:0]  cmd_rl;
   logic [2:0]  cmd_mode;
   logic        cmd_bcd;
   logic [15:0] cmd_value;
   logic        rsp_valid;
   logic        rsp_err;
   logic [15:0] rsp_data;
   logic        cs;
   logic        rd;
   logic        wr;
   logic [1:0]  a;
   logic [7:0]  odata;
   logic [7:0]  idata;

   modport master (
      input  cmd_valid, cmd_op, cmd_chan, cmd_rl, cmd_mode, cmd_bcd, cmd_value, idata,
      output cmd_ready, rsp_valid, rsp_err, rsp_data, cs, rd, wr, a, odata
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_chan, cmd_rl, cmd_mode, cmd_bcd, cmd_value, idata,
      input  cmd_ready, rsp_valid, rsp_err, rsp_data, cs, rd, wr, a, odata
   );
endinterface

// File: rtl/pit_host.sv
// i8253 bus initiator: expands program/read commands into cs/rd/wr/a byte accesses.
// Read commands are sequenced only when PIT_HOST_READBACK_EN is defined.
module pit_host #(
   parameter int unsigned RD_CYCLES = 2,
   parameter int unsigned GAP       = 1
) (
   input logic        clk,
   input logic        reset,
   pit_host_if.master bus
);
   localparam int unsigned PW = $clog2(RD_CYCLES + GAP + 3);
   localparam logic [PW-1:0] STROBE_PH = PW'(1);
   localparam logic [PW-1:0] WR_LAST   = PW'(2);
   localparam logic [PW-1:0] GAP_LAST  = PW'((GAP > 0) ? GAP - 1 : 0);
`ifdef PIT_HOST_READBACK_EN
   localparam logic [PW-1:0] RD_STROBE_LAST = PW'(RD_CYCLES);
   localparam logic [PW-1:0] RD_LAST        = PW'(RD_CYCLES + 1);
`endif

   typedef enum logic [2:0] {S_IDLE, S_CW, S_GAP, S_D0, S_D1, S_RESP} state_t;

   state_t      state_q, state_d, after_gap_q, after_gap_d, nxt_acc;
   logic [PW-1:0] phase_q, phase_d, last_phase;
   logic        rsp_err_q, rsp_err_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic [1:0]  chan_q, rl_q;
   logic [2:0]  mode_q;
   logic        bcd_q;
   logic [15:0] value_q;
   logic        ready, accept, bad_cmd, in_access, rd_cmd, acc_done;
   logic [7:0]  acc_byte;

   assign ready     = (state_q == S_IDLE) && !reset;
   assign accept    = bus.cmd_valid && ready;
   assign in_access = (state_q == S_CW) || (state_q == S_D0) || (state_q == S_D1);

`ifdef PIT_HOST_READBACK_EN
   logic       op_q, rd_acc;
   logic [7:0] lsb_q, lsb_d, msb_q, msb_d;

   assign rd_cmd     = op_q;
   assign rd_acc     = op_q && ((state_q == S_D0) || (state_q == S_D1));
   assign bad_cmd    = (bus.cmd_chan == 2'd3);
   assign last_phase = rd_acc ? RD_LAST : WR_LAST;

   always_comb begin
      lsb_d = lsb_q;
      msb_d = msb_q;
      if (rd_acc && phase_q == RD_STROBE_LAST) begin
         if (state_q == S_D0) lsb_d = bus.idata;
         else                 msb_d = bus.idata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q  <= 1'b0;
         lsb_q <= '0;
         msb_q <= '0;
      end else begin
         if (accept) op_q <= bus.cmd_op;
         lsb_q <= lsb_d;
         msb_q <= msb_d;
      end
   end
`else
   assign rd_cmd     = 1'b0;
   assign bad_cmd    = (bus.cmd_chan == 2'd3) || bus.cmd_op;
   assign last_phase = WR_LAST;
`endif

   assign acc_done = in_access && (phase_q == last_phase);

   always_comb begin
      nxt_acc  = S_RESP;
      acc_byte = '0;
      case (state_q)
         S_CW: begin
            nxt_acc  = S_D0;
            acc_byte = rd_cmd ? {chan_q, 6'b000000} : {chan_q, rl_q, mode_q, bcd_q};
         end
         S_D0: begin
            nxt_acc  = (rd_cmd || rl_q == 2'b11) ? S_D1 : S_RESP;
            acc_byte = (rl_q == 2'b10) ? value_q[15:8] : value_q[7:0];
         end
         S_D1:    acc_byte = value_q[15:8];
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      after_gap_d = after_gap_q;
      phase_d     = phase_q;
      rsp_err_d   = rsp_err_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         S_IDLE: if (accept) begin
            phase_d = '0;
            if (bad_cmd) begin
               state_d    = S_RESP;
               rsp_err_d  = 1'b1;
               rsp_data_d = '0;
            end else begin
               state_d = S_CW;
            end
         end
         S_CW, S_D0, S_D1: if (acc_done) begin
            phase_d = '0;
            if (nxt_acc == S_RESP) begin
               state_d    = S_RESP;
               rsp_err_d  = 1'b0;
`ifdef PIT_HOST_READBACK_EN
               rsp_data_d = rd_cmd ? {msb_q, lsb_q} : 16'h0000;
`else
               rsp_data_d = '0;
`endif
            end else if (GAP > 0) begin
               state_d     = S_GAP;
               after_gap_d = nxt_acc;
            end else begin
               state_d = nxt_acc;
            end
         end else begin
            phase_d = phase_q + 1'b1;
         end
         S_GAP: if (phase_q == GAP_LAST) begin
            state_d = after_gap_q;
            phase_d = '0;
         end else begin
            phase_d = phase_q + 1'b1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         after_gap_q <= S_IDLE;
         phase_q     <= '0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         after_gap_q <= after_gap_d;
         phase_q     <= phase_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // rl=00 is folded to 11 at capture so the control word and data phases agree
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chan_q  <= '0;
         rl_q    <= '0;
         mode_q  <= '0;
         bcd_q   <= 1'b0;
         value_q <= '0;
      end else if (accept) begin
         chan_q  <= bus.cmd_chan;
         rl_q    <= (bus.cmd_rl == 2'b00) ? 2'b11 : bus.cmd_rl;
         mode_q  <= bus.cmd_mode;
         bcd_q   <= bus.cmd_bcd;
         value_q <= bus.cmd_value;
      end
   end

   always_comb begin
      bus.cs    = 1'b0;
      bus.rd    = 1'b0;
      bus.wr    = 1'b0;
      bus.a     = '0;
      bus.odata = '0;
      if (in_access) begin
         bus.cs = 1'b1;
         bus.a  = (state_q == S_CW) ? 2'd3 : chan_q;
`ifdef PIT_HOST_READBACK_EN
         if (rd_acc) begin
            bus.rd = (phase_q >= STROBE_PH) && (phase_q <= RD_STROBE_LAST);
         end else begin
            bus.wr    = (phase_q == STROBE_PH);
            bus.odata = acc_byte;
         end
`else
         bus.wr    = (phase_q == STROBE_PH);
         bus.odata = acc_byte;
`endif
      end
   end

   assign bus.cmd_ready = ready;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_pit_host.sv
// Randomized bench for pit_host: per-cycle comparison against a timeline built from the
// command rules, an attached simplified i8253 timer, and literal pins on the directed cases.
module tb_pit_host;
   localparam int unsigned RD = 2;
   localparam int unsigned GP = 1;
`ifdef PIT_HOST_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct {
      bit       cs, rd, wr;
      bit [1:0] a;
      bit [7:0] od;
      bit       od_chk;
      bit       rv, err, rd_cmd;
      bit [1:0] ch;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   pit_host_if bus();

   pit_host #(.RD_CYCLES(RD), .GAP(GP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- simplified i8253 attached to the bus ----------------
   logic [15:0] tm_cnt[4], tm_lat[4];
   logic [7:0]  tm_lsb[4];
   logic [1:0]  tm_rl[4];
   bit          tm_wtog[4], tm_rtog[4];
   bit          prev_rd = 1'b0;
   logic [1:0]  prev_a = '0;

   initial begin
      for (int c = 0; c < 4; c++) begin
         tm_cnt[c] = 16'(16'h3000 + c * 16'h0111);
         tm_lat[c] = '0; tm_lsb[c] = '0; tm_rl[c] = 2'b11;
         tm_wtog[c] = 1'b0; tm_rtog[c] = 1'b0;
      end
   end

   assign bus.idata = (bus.cs && bus.rd && bus.a != 2'd3) ?
                      (tm_rtog[bus.a] ? tm_lat[bus.a][15:8] : tm_lat[bus.a][7:0]) : 8'hA5;

   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) tm_cnt[c] = tm_cnt[c] - 16'd1;
      if (!reset && bus.cs && bus.wr) begin
         if (bus.a == 2'd3) begin
            if (bus.odata[7:6] != 2'd3) begin
               if (bus.odata[5:4] == 2'b00) begin
                  tm_lat[bus.odata[7:6]]  = tm_cnt[bus.odata[7:6]];
                  tm_rtog[bus.odata[7:6]] = 1'b0;
               end else begin
                  tm_rl[bus.odata[7:6]]   = bus.odata[5:4];
                  tm_wtog[bus.odata[7:6]] = 1'b0;
               end
            end
         end else begin
            case (tm_rl[bus.a])
               2'b01: tm_cnt[bus.a] = {8'h00, bus.odata};
               2'b10: tm_cnt[bus.a] = {bus.odata, 8'h00};
               default: begin
                  if (!tm_wtog[bus.a]) tm_lsb[bus.a] = bus.odata;
                  else                 tm_cnt[bus.a] = {bus.odata, tm_lsb[bus.a]};
                  tm_wtog[bus.a] = !tm_wtog[bus.a];
               end
            endcase
         end
      end
      // byte pointer advances once the rd strobe has ended
      if (prev_rd && !bus.rd) tm_rtog[prev_a] = !tm_rtog[prev_a];
      prev_rd = bus.rd;
      prev_a  = bus.a;
   end

   // ---------------- expected timeline ----------------
   exp_t        expq[$];
   bit          busy_now = 1'b0;
   bit          last_err = 1'b0;
   logic [15:0] last_data = '0;

   function automatic exp_t quiet();
      exp_t e;
      e.cs = 0; e.rd = 0; e.wr = 0; e.a = 0; e.od = 0; e.od_chk = 1;
      e.rv = 0; e.err = 0; e.rd_cmd = 0; e.ch = 0;
      return e;
   endfunction

   task automatic build(input bit op, input bit [1:0] ch, input bit [1:0] rl,
                        input bit [2:0] mode, input bit bcd, input bit [15:0] val);
      bit       acc_rd[$];
      bit [1:0] acc_a[$];
      bit [7:0] acc_d[$];
      bit [1:0] rle;
      exp_t     e;
      rle = (rl == 2'b00) ? 2'b11 : rl;
      if (ch == 2'd3 || (op && !RB)) begin
         e = quiet(); e.rv = 1; e.err = 1;
         expq.push_back(e);
      end else begin
         if (op) begin
            acc_rd.push_back(0); acc_a.push_back(2'd3); acc_d.push_back({ch, 6'b000000});
            repeat (2) begin acc_rd.push_back(1); acc_a.push_back(ch); acc_d.push_back(8'h00); end
         end else begin
            acc_rd.push_back(0); acc_a.push_back(2'd3); acc_d.push_back({ch, rle, mode, bcd});
            if (rle != 2'b10) begin acc_rd.push_back(0); acc_a.push_back(ch); acc_d.push_back(val[7:0]); end
            if (rle != 2'b01) begin acc_rd.push_back(0); acc_a.push_back(ch); acc_d.push_back(val[15:8]); end
         end
         foreach (acc_a[i]) begin
            if (i > 0) repeat (GP) expq.push_back(quiet());
            e = quiet(); e.cs = 1; e.a = acc_a[i]; e.od = acc_d[i]; e.od_chk = !acc_rd[i];
            expq.push_back(e);
            if (acc_rd[i]) begin e.rd = 1; repeat (RD) expq.push_back(e); e.rd = 0; end
            else begin e.wr = 1; expq.push_back(e); e.wr = 0; end
            expq.push_back(e);
         end
         e = quiet(); e.rv = 1; e.rd_cmd = op; e.ch = ch;
         expq.push_back(e);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         expq.delete();
         busy_now = 1'b0; last_err = 1'b0; last_data = '0;
         chk("rst_ready", bus.cmd_ready, 0);
         chk("rst_bus", {bus.cs, bus.rd, bus.wr, bus.a, bus.odata}, 0);
         chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
      end else begin
         busy_now = (expq.size() != 0);
         chk("cmd_ready", bus.cmd_ready, !busy_now);
         e = quiet();
         if (busy_now) e = expq.pop_front();
         chk("cs", bus.cs, e.cs);
         chk("rd", bus.rd, e.rd);
         chk("wr", bus.wr, e.wr);
         chk("a", bus.a, e.a);
         if (e.od_chk) chk("odata", bus.odata, e.od);
         chk("rsp_valid", bus.rsp_valid, e.rv);
         if (e.rv) begin
            last_err  = e.err;
            last_data = e.rd_cmd ? tm_lat[e.ch] : 16'h0000;
         end
         chk("rsp_err", bus.rsp_err, last_err);
         chk("rsp_data", bus.rsp_data, last_data);
      end
   end

   // ---------------- observation for literal pins ----------------
   logic [9:0] wlog[$];
   int rsp_cyc = -1, acc_cyc = 0, cs_cnt = 0, rd_run = 0, rd_max = 0;

   always @(negedge clk) if (!reset) begin
      if (bus.cs && bus.wr) wlog.push_back({bus.a, bus.odata});
      if (bus.cs) cs_cnt++;
      if (bus.rsp_valid) rsp_cyc = cyc;
      if (bus.rd) begin rd_run++; if (rd_run > rd_max) rd_max = rd_run; end
      else rd_run = 0;
   end

   // ---------------- driver ----------------
   task automatic scramble();
      bus.cmd_op    = 1'($urandom);
      bus.cmd_chan  = 2'($urandom);
      bus.cmd_rl    = 2'($urandom);
      bus.cmd_mode  = 3'($urandom);
      bus.cmd_bcd   = 1'($urandom);
      bus.cmd_value = 16'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk); #1;
         n++;
         if (busy_now) begin bus.cmd_valid = 1'($urandom); scramble(); end
      end while (busy_now && n < 100);
      bus.cmd_valid = 1'b0;
      if (busy_now) begin
         errors++;
         $display("FAIL idle_timeout: still busy after %0d cycles", n);
      end
   endtask

   task automatic issue(input bit op, input bit [1:0] ch, input bit [1:0] rl,
                        input bit [2:0] mode, input bit bcd, input bit [15:0] val);
      wait_idle();
      bus.cmd_op = op; bus.cmd_chan = ch; bus.cmd_rl = rl;
      bus.cmd_mode = mode; bus.cmd_bcd = bcd; bus.cmd_value = val;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc - 1;
      build(op, ch, rl, mode, bcd, val);
      bus.cmd_valid = 1'b0;
      scramble();
   endtask

   task automatic clear_obs();
      wlog.delete(); rsp_cyc = -1; cs_cnt = 0; rd_max = 0;
   endtask

   initial begin
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      scramble();
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;

      // program rl=11, chan 0, mode 2, value 0x1234
      clear_obs();
      issue(0, 2'd0, 2'b11, 3'd2, 0, 16'h1234);
      wait_idle();
      chk("p11_writes", wlog.size(), 3);
      chk("p11_cw", wlog[0], {2'd3, 8'h34});
      chk("p11_lsb", wlog[1], {2'd0, 8'h34});
      chk("p11_msb", wlog[2], {2'd0, 8'h12});
      chk("p11_rsp_cycle", rsp_cyc - acc_cyc, 12);

      // program rl=01, chan 2, mode 3, value 0x00AA
      clear_obs();
      issue(0, 2'd2, 2'b01, 3'd3, 0, 16'h00AA);
      wait_idle();
      chk("p01_writes", wlog.size(), 2);
      chk("p01_cw", wlog[0], {2'd3, 8'h96});
      chk("p01_lsb", wlog[1], {2'd2, 8'hAA});
      chk("p01_rsp_cycle", rsp_cyc - acc_cyc, 8);

      // program chan 1 with 0x0100, then latch-and-read it
      issue(0, 2'd1, 2'b11, 3'd2, 0, 16'h0100);
      wait_idle();
      clear_obs();
      issue(1, 2'd1, 2'b00, 3'd0, 0, 16'h0000);
      wait_idle();
`ifdef PIT_HOST_READBACK_EN
      chk("rd_writes", wlog.size(), 1);
      chk("rd_latch_cw", wlog[0], {2'd3, 8'h40});
      chk("rd_rsp_cycle", rsp_cyc - acc_cyc, 14);
      chk("rd_strobe_width", rd_max, 2);
      chk("rd_err", bus.rsp_err, 0);
`else
      chk("rd_off_cs", cs_cnt, 0);
      chk("rd_off_rsp_cycle", rsp_cyc - acc_cyc, 1);
      chk("rd_off_err", bus.rsp_err, 1);
`endif

      // illegal channel
      clear_obs();
      issue(0, 2'd3, 2'b11, 3'd0, 0, 16'hFFFF);
      wait_idle();
      chk("ill_cs", cs_cnt, 0);
      chk("ill_rsp_cycle", rsp_cyc - acc_cyc, 1);
      chk("ill_err", bus.rsp_err, 1);

      // reset during the second access's write strobe
      clear_obs();
      issue(0, 2'd0, 2'b11, 3'd2, 0, 16'h5678);
      for (int k = 0; k < 20 && (cyc - acc_cyc) != 6; k++) @(negedge clk);
      #1;
      chk("mid_pre_wr", bus.wr, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_cs", bus.cs, 0);
      chk("mid_rst_wr", bus.wr, 0);
      @(negedge clk); #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_no_rsp", rsp_cyc, -1);
      clear_obs();
      issue(0, 2'd0, 2'b11, 3'd2, 0, 16'h1234);
      wait_idle();
      chk("post_rst_writes", wlog.size(), 3);
      chk("post_rst_rsp_cycle", rsp_cyc - acc_cyc, 12);

      // randomized commands with junk offered while busy
      repeat (150) begin
         bit [1:0] ch;
         ch = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
         issue(1'($urandom), ch, 2'($urandom), 3'($urandom_range(0, 5)), 1'($urandom), 16'($urandom));
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
